mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
// PURPOSE
//  Memory-side initiator for the 16-bit processor's two-port 16x1k data memory: copies LENGTH words
//  from SRC to DST, reading on memory port 1 and writing on memory port 2. Reads are issued
//  back-to-back; writes trail them by READ_LAT cycles. Sits beside the CPU as a block-move helper.
// PARAMETERS
//  DATA_W    16    memory word width
//  ADDR_W    16    memory address width
//  DEPTH     1024  number of valid words; addresses >= DEPTH are out of range
//  READ_LAT  1     cycles from Read1 high to valid R1 (1..4)
// PORTS
//  clk          in   1       system clock; all state changes on posedge
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       request pulse; sampled only in IDLE
//  src_addr     in   ADDR_W  first source word address
//  dst_addr     in   ADDR_W  first destination word address
//  length       in   ADDR_W  words to copy; 0 = no-op
//  busy         out  1       copy in progress
//  done         out  1       one-cycle completion pulse
//  err          out  1       last request was rejected (range/overlap)
//  A1           out  ADDR_W  port-1 read address
//  Read1        out  1       port-1 read strobe
//  R1           in   DATA_W  port-1 read data, valid READ_LAT cycles after Read1
//  A2           out  ADDR_W  port-2 write address
//  W2           out  DATA_W  port-2 write data
//  Write2       out  1       port-2 write strobe
//  checksum     out  DATA_W  (MEM_COPY_CHECKSUM_EN only) mod-2^16 sum of copied words
// BEHAVIOUR
//  - Reset: busy=done=err=Read1=Write2=0; A1=A2=W2=0; checksum=0; FSM=IDLE. Clears immediately (async);
//    mid-copy reset abandons the copy; words already written stay written.
//  - States: IDLE -> CHECK -> RUN -> DONE -> IDLE. start in IDLE latches src/dst/length -> CHECK.
//  - CHECK (1 cycle, busy=1): reject if src+length>DEPTH, dst+length>DEPTH (17-bit compare, no wrap),
//    or forward overlap (src<dst<src+length). Reject -> DONE with err=1, no memory access.
//    length=0 -> DONE with err=0, no access. Otherwise -> RUN.
//  - RUN: read i (i=0..length-1) in RUN cycle i: Read1=1, A1=src+i. Write i in RUN cycle i+READ_LAT:
//    Write2=1, A2=dst+i, W2=R1 captured from read i. Read and write overlap in one cycle when
//    length>READ_LAT. RUN lasts length+READ_LAT cycles; Read1 is never high after the last read.
//  - DONE (1 cycle): done=1, busy=0, strobes low -> IDLE. err is set here on reject and cleared on
//    the next accepted start. An accepted copy takes 1+length+READ_LAT cycles of busy.
//  - start while busy or in DONE is ignored (not queued). Inputs are sampled only at acceptance.
//  - Backward overlap (dst<src) is legal and correct, since each read precedes the write that could
//    clobber it. dst==src is legal (rewrite in place).
// CONFIGURATION
//  MEM_COPY_CHECKSUM_EN defined: checksum port present; cleared on accepted start, += W2 on each
//    write, holds after done until next start. Undefined: no checksum port and no adder.
// STRUCTURE
//  Shared header mem_pkg.vh: MEM_DATA_W, MEM_ADDR_W, MEM_DEPTH and the FSM state encodings
//  (IDLE/CHECK/RUN/DONE), shared with the memory and its testbenches.
//  Sub-module mem_copy_delay: READ_LAT-deep shift register carrying {valid, dst address} from the
//  read issue to the write slot.
// TESTING
//  1 src=0,dst=500,len=4, mem[0..3]=10,11,12,13, READ_LAT=1 -> Read1 in cycles 2-5 (after start),
//    Write2 in 3-6, mem[500..503]=10..13, done in cycle 7, err=0.
//  2 len=0 -> busy 1 cycle, done next cycle, err=0, Read1/Write2 never high.
//  3 src=1020,len=8 -> err=1 with done, no strobe ever high. Then a legal start -> err back to 0.
//  4 src=100,dst=102,len=5 -> err=1 (forward overlap). src=102,dst=100,len=5 -> accepted,
//    mem[100..104] = original mem[102..106].
//  5 Assert reset during RUN after 3 of 6 writes -> all strobes 0 the same instant. dst+0..2 are
//    written, dst+3..5 unchanged. Next start completes normally.
//  6 MEM_COPY_CHECKSUM_EN, copy 3 words 0xFFFF,0x0002,0x0010 -> checksum=0x0011. start pulsed while
//    busy -> ignored, no second done.

Source files
------------

// File: rtl/mem_copy_engine_pkg.sv
// Shared widths, FSM encoding and request legality check for the block-move helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_copy_engine_pkg;

  localparam int MEM_DATA_W   = 16;
  localparam int MEM_ADDR_W   = 16;
  localparam int MEM_DEPTH    = 1024;
  localparam int MEM_READ_LAT = 1;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef logic [MEM_DATA_W-1:0] data_t;
  typedef logic [MEM_ADDR_W:0]   addr_ext_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One bit of headroom so src+length never wraps; forward overlap would clobber unread source words.
  function automatic logic req_reject(input addr_t src, input addr_t dst, input addr_t len);
    addr_ext_t w_src_end;
    addr_ext_t w_dst_end;
    addr_ext_t w_depth;
    w_src_end = {1'b0, src} + {1'b0, len};
    w_dst_end = {1'b0, dst} + {1'b0, len};
    w_depth   = addr_ext_t'(MEM_DEPTH);
    return (w_src_end > w_depth) || (w_dst_end > w_depth) ||
           ((src < dst) && ({1'b0, dst} < w_src_end));
  endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// Request/status handshake plus the two memory ports of the copy engine.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are fire-and-forget toward the memory.
interface mem_copy_engine_if;
  import mem_copy_engine_pkg::*;

  logic  start;
  addr_t src_addr;
  addr_t dst_addr;
  addr_t length;
  logic  busy;
  logic  done;
  logic  err;
  addr_t A1;
  logic  Read1;
  data_t R1;
  addr_t A2;
  data_t W2;
  logic  Write2;
`ifdef MEM_COPY_CHECKSUM_EN
  data_t checksum;

  modport engine (
    input  start, src_addr, dst_addr, length, R1,
    output busy, done, err, A1, Read1, A2, W2, Write2, checksum
  );
  modport host (
    output start, src_addr, dst_addr, length, R1,
    input  busy, done, err, A1, Read1, A2, W2, Write2, checksum
  );
`else
  modport engine (
    input  start, src_addr, dst_addr, length, R1,
    output busy, done, err, A1, Read1, A2, W2, Write2
  );
  modport host (
    output start, src_addr, dst_addr, length, R1,
    input  busy, done, err, A1, Read1, A2, W2, Write2
  );
`endif

endinterface

// File: rtl/mem_copy_engine_delay.sv
// Shift register carrying {valid, write address} from read issue to the matching write slot.
// Latency: LAT cycles, fixed.
// Backpressure: none; one entry per cycle in and out.
module mem_copy_engine_delay #(
  parameter int LAT = 1,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic [LAT-1:0] r_vld;
  logic [W-1:0]   r_dat [LAT];

  // Advance every stage each cycle; reset empties the pipe so no stale write survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_dat[0] <= i_dat;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_vld = r_vld[LAT-1];
  assign o_dat = r_dat[LAT-1];

endmodule

// File: rtl/mem_copy_engine.sv
// Block-move helper: copies length words src->dst, reading port 1, writing port 2 READ_LAT later.
// Latency: 1 check cycle + length + READ_LAT run cycles, then a 1-cycle done pulse.
// Backpressure: none; start is only sampled in IDLE, otherwise dropped. Option: MEM_COPY_CHECKSUM_EN.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int READ_LAT = MEM_READ_LAT
) (
  input logic         clk,
  input logic         reset,
  mem_copy_engine_if.engine bus
);

  state_t    r_state;
  state_t    w_next;
  addr_t     r_src;
  addr_t     r_dst;
  addr_t     r_len;
  addr_ext_t r_cnt;
  logic      r_err;

  logic      w_reject;
  logic      w_last_run;
  logic      w_rd_en;
  addr_t     w_rd_addr;
  addr_t     w_wr_addr_in;
  logic      w_wr_vld;
  addr_t     w_wr_addr;
  logic      w_wr_en;

  assign w_reject     = req_reject(r_src, r_dst, r_len);
  assign w_rd_en      = (r_state == ST_RUN) && (r_cnt < {1'b0, r_len});
  assign w_last_run   = (r_cnt == ({1'b0, r_len} + addr_ext_t'(READ_LAT - 1)));
  assign w_rd_addr    = r_src + r_cnt[MEM_ADDR_W-1:0];
  assign w_wr_addr_in = r_dst + r_cnt[MEM_ADDR_W-1:0];
  assign w_wr_en      = w_wr_vld && (r_state == ST_RUN);

  mem_copy_engine_delay #(
    .LAT (READ_LAT),
    .W   (MEM_ADDR_W)
  ) u_delay (
    .clk   (clk),
    .rst   (reset),
    .i_vld (w_rd_en),
    .i_dat (w_wr_addr_in),
    .o_vld (w_wr_vld),
    .o_dat (w_wr_addr)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: one check cycle, run until the last trailing write, then a single done cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_CHECK;
      ST_CHECK: w_next = (w_reject || (r_len == '0)) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_last_run) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs: addresses and write data are forced to zero whenever their strobe is low.
  always_comb begin
    bus.busy   = (r_state == ST_CHECK) || (r_state == ST_RUN);
    bus.done   = (r_state == ST_DONE);
    bus.err    = r_err;
    bus.Read1  = w_rd_en;
    bus.A1     = w_rd_en ? w_rd_addr : '0;
    bus.Write2 = w_wr_en;
    bus.A2     = w_wr_en ? w_wr_addr : '0;
    bus.W2     = w_wr_en ? bus.R1 : '0;
  end

  // Request capture, run counter and sticky reject flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_src <= bus.src_addr;
          r_dst <= bus.dst_addr;
          r_len <= bus.length;
          r_err <= 1'b0;
        end
        ST_CHECK: begin
          r_cnt <= '0;
          if (w_reject) r_err <= 1'b1;
        end
        ST_RUN:  r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  data_t r_checksum;

  // Running mod-2^16 sum of written words, restarted by each accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_checksum <= '0;
    else if ((r_state == ST_IDLE) && bus.start) r_checksum <= '0;
    else if (w_wr_en)                           r_checksum <= r_checksum + bus.R1;
  end

  assign bus.checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: per-cycle trace scoreboard plus memory image check.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_copy_engine;

  localparam int TB_LAT = 1;
  localparam int DEPTH  = 1024;

  typedef struct packed {
    bit          busy;
    bit          done;
    bit          err;
    bit          rd;
    bit          wr;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] w2;
  } exp_t;

  logic clk;
  logic reset;
  mem_copy_engine_if bus();

  mem_copy_engine #(.READ_LAT(TB_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem     [DEPTH];
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] rd_pipe [TB_LAT];
  exp_t        exp_q [$];
  exp_t        cur;
  bit          last_err;
  logic [15:0] exp_cksum;
  int          errors;
  int          checks;

  assign bus.R1 = rd_pipe[TB_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Memory model: registered read with TB_LAT stages, write on strobe.
  always @(posedge clk) begin
    if (bus.Write2) mem[bus.A2[9:0]] <= bus.W2;
    rd_pipe[0] <= mem[bus.A1[9:0]];
    for (int i = 1; i < TB_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Per-cycle compare against the expected trace (idle expectations when the trace is empty).
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_read1", bus.Read1, 0);
      chk("rst_write2", bus.Write2, 0);
      chk("rst_a1", bus.A1, 0);
      chk("rst_a2", bus.A2, 0);
      chk("rst_w2", bus.W2, 0);
`ifdef MEM_COPY_CHECKSUM_EN
      chk("rst_cksum", bus.checksum, 0);
`endif
    end else begin
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        last_err = cur.err;
      end else begin
        cur = '0;
        cur.err = last_err;
      end
      chk("busy", bus.busy, cur.busy);
      chk("done", bus.done, cur.done);
      chk("err", bus.err, cur.err);
      chk("read1", bus.Read1, cur.rd);
      chk("write2", bus.Write2, cur.wr);
      if (cur.rd) chk("a1", bus.A1, cur.a1);
      if (cur.wr) begin
        chk("a2", bus.A2, cur.a2);
        chk("w2", bus.W2, cur.w2);
      end
    end
  end

  // Issue one request: build its whole cycle trace from the request rules, then pulse start.
  task automatic start_copy(input int s, input int d, input int l);
    bit          rej;
    bit          run;
    int          n;
    exp_t        e;
    logic [15:0] snap [$];
    @(posedge clk); #1;
    bus.src_addr = 16'(s);
    bus.dst_addr = 16'(d);
    bus.length   = 16'(l);
    bus.start    = 1'b1;
    rej = (s + l > DEPTH) || (d + l > DEPTH) || ((s < d) && (d < s + l));
    run = !rej && (l != 0);
    n   = run ? (3 + l + TB_LAT) : 3;
    snap.delete();
    if (run) for (int j = 0; j < l; j++) snap.push_back(ref_mem[s + j]);
    for (int k = 0; k < n; k++) begin
      e = '0;
      e.busy = (k >= 1) && (k < n - 1);
      e.done = (k == n - 1);
      e.err  = (k == 0) ? last_err : ((k == n - 1) ? rej : 1'b0);
      if (run && k >= 2) begin
        if (k - 2 < l) begin
          e.rd = 1'b1;
          e.a1 = 16'(s + k - 2);
        end
        if ((k - 2 >= TB_LAT) && (k - 2 - TB_LAT < l)) begin
          e.wr = 1'b1;
          e.a2 = 16'(d + k - 2 - TB_LAT);
          e.w2 = snap[k - 2 - TB_LAT];
        end
      end
      exp_q.push_back(e);
    end
    exp_cksum = '0;
    if (run) for (int j = 0; j < l; j++) begin
      ref_mem[d + j] = snap[j];
      exp_cksum = exp_cksum + snap[j];
    end
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.src_addr = 16'($urandom);
    bus.dst_addr = 16'($urandom);
    bus.length   = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("idle_timeout", (exp_q.size() != 0), 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("checksum", bus.checksum, exp_cksum);
`endif
  endtask

  task automatic check_mem();
    int mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);
  endtask

  initial begin
    logic [7:0]  rd_m, wr_m, dn_m, bz_m;
    logic [15:0] orig [5];
    logic [15:0] keep [3];
    int s, d, l, m;
    errors = 0;
    checks = 0;
    last_err = 1'b0;
    exp_cksum = '0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.length = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < TB_LAT; i++) rd_pipe[i] = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed copy with known data and hand-derived cycle positions.
    for (int i = 0; i < 4; i++) begin
      mem[i] = 16'(10 + i);
      ref_mem[i] = 16'(10 + i);
    end
    start_copy(0, 500, 4);
    rd_m = '0; wr_m = '0; dn_m = '0; bz_m = '0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      rd_m[c] = bus.Read1;
      wr_m[c] = bus.Write2;
      dn_m[c] = bus.done;
      bz_m[c] = bus.busy;
    end
    @(negedge clk);
    dn_m[0] = bus.done;
    chk("t1_read_cycles", rd_m, 8'b0011_1100);
    chk("t1_write_cycles", wr_m, 8'b0111_1000);
    chk("t1_done_cycle7", dn_m, 8'b1000_0000);
    chk("t1_busy_cycles", bz_m, 8'b0111_1110);
    wait_idle();
    chk("t1_mem500", mem[500], 16'd10);
    chk("t1_mem503", mem[503], 16'd13);
    chk("t1_err", bus.err, 0);
    check_mem();

    // Zero length: one busy cycle then done.
    start_copy(50, 60, 0);
    bz_m = '0; dn_m = '0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      bz_m[c] = bus.busy;
      dn_m[c] = bus.done;
    end
    chk("t2_busy", bz_m, 8'b0000_0010);
    chk("t2_done", dn_m, 8'b0000_0100);
    wait_idle();

    // Out of range, then a legal request clears err.
    start_copy(1020, 10, 8);
    @(negedge clk);
    @(negedge clk);
    chk("t3_err_with_done", {bus.done, bus.err}, 2'b11);
    wait_idle();
    start_copy(200, 300, 3);
    chk("t3_err_cleared", bus.err, 0);
    wait_idle();

    // Forward overlap rejected, backward overlap copies correctly.
    start_copy(100, 102, 5);
    wait_idle();
    chk("t4_fwd_err", bus.err, 1);
    for (int i = 0; i < 5; i++) orig[i] = mem[102 + i];
    start_copy(102, 100, 5);
    wait_idle();
    chk("t4_bwd_err", bus.err, 0);
    for (int i = 0; i < 5; i++) chk("t4_bwd_data", mem[100 + i], orig[i]);
    check_mem();

    // Reset after three of six writes.
    for (int i = 0; i < 3; i++) keep[i] = ref_mem[703 + i];
    start_copy(600, 700, 6);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    last_err = 1'b0;
    exp_cksum = '0;
    for (int i = 0; i < 3; i++) ref_mem[703 + i] = keep[i];
    #1;
    chk("t5_strobes_now", {bus.Read1, bus.Write2, bus.busy}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0;
    check_mem();
    start_copy(600, 700, 6);
    wait_idle();
    check_mem();

    // Checksum wrap and starts ignored while busy and in done.
    mem[800] = 16'hFFFF; ref_mem[800] = 16'hFFFF;
    mem[801] = 16'h0002; ref_mem[801] = 16'h0002;
    mem[802] = 16'h0010; ref_mem[802] = 16'h0010;
    start_copy(800, 900, 3);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.src_addr = 16'd5; bus.dst_addr = 16'd6; bus.length = 16'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t6_checksum_lit", bus.checksum, 16'h0011);
`endif
    repeat (4) @(posedge clk);
    check_mem();

    // Randomized requests mixing legal, out-of-range, overlapping and in-place copies.
    for (int it = 0; it < 40; it++) begin
      l = $urandom_range(0, 20);
      s = $urandom_range(0, DEPTH - 1);
      m = $urandom_range(0, 3);
      case (m)
        0: d = $urandom_range(0, DEPTH - 1);
        1: d = (s + $urandom_range(0, 24) - 12) & 16'hFFFF;
        2: begin
          s = DEPTH - $urandom_range(0, 24);
          d = $urandom_range(0, DEPTH - 1);
        end
        default: d = s;
      endcase
      if (l == 0 && d >= DEPTH) d = 0;
      start_copy(s, d, l);
      wait_idle();
      check_mem();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
